// File: rtl/pdm_capture_ctrl.sv
// Stereo PDM front-end sequencer: mic clock, CIC sample/decimation strobes,
// settle-time frame discard and a valid/ready PCM output register.
module pdm_capture_ctrl #(
   parameter int DIV_HALF = 10,
   parameter int DECIM    = 128,
   parameter int SETTLE   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   output logic               clk_pdm,
   output logic               en_left,
   output logic               en_right,
   output logic               en_pcm,
   input  logic signed [15:0] pcm_l_in,
   input  logic signed [15:0] pcm_r_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_l,
   output logic signed [15:0] out_r,
   output logic               overrun,
   output logic               settled
);

   localparam int PW = $clog2(2 * DIV_HALF);
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int SW = ($clog2(SETTLE + 1) > 0) ? $clog2(SETTLE + 1) : 1;

   localparam logic [PW-1:0] P_LAST  = PW'(2 * DIV_HALF - 1);
   localparam logic [PW-1:0] P_HALF  = PW'(DIV_HALF);
   localparam logic [PW-1:0] P_LEFT  = PW'(DIV_HALF - 3);
   localparam logic [PW-1:0] P_RIGHT = PW'(2 * DIV_HALF - 3);
   localparam logic [DW-1:0] D_LAST  = DW'(DECIM - 1);
   localparam logic [SW-1:0] S_LAST  = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      p_q, p_d;
   logic [DW-1:0]      d_q, d_d;
   logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
   logic               clk_pdm_q, clk_pdm_d;
   logic               en_left_q, en_left_d;
   logic               en_right_q, en_right_d;
   logic               en_pcm_q, en_pcm_d;
   logic               capture_q, capture_d;
   logic               out_valid_q, out_valid_d;
   logic               overrun_q, overrun_d;
   logic               settled_q, settled_d;
   logic signed [15:0] out_l_q, out_l_d;
   logic signed [15:0] out_r_q, out_r_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         p_q          <= '0;
         d_q          <= '0;
         settle_cnt_q <= '0;
         clk_pdm_q    <= 1'b0;
         en_left_q    <= 1'b0;
         en_right_q   <= 1'b0;
         en_pcm_q     <= 1'b0;
         capture_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         settled_q    <= 1'b0;
         out_l_q      <= '0;
         out_r_q      <= '0;
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         d_q          <= d_d;
         settle_cnt_q <= settle_cnt_d;
         clk_pdm_q    <= clk_pdm_d;
         en_left_q    <= en_left_d;
         en_right_q   <= en_right_d;
         en_pcm_q     <= en_pcm_d;
         capture_q    <= capture_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
         settled_q    <= settled_d;
         out_l_q      <= out_l_d;
         out_r_q      <= out_r_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
            ST_SETTLE: if (capture_q && settle_cnt_q == S_LAST) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Strobes and clk_pdm are decoded from the next phase so they line up with p_q.
   always_comb begin
      p_d          = p_q;
      d_d          = d_q;
      settle_cnt_d = settle_cnt_q;
      out_valid_d  = out_valid_q;
      overrun_d    = overrun_q;
      settled_d    = settled_q;
      out_l_d      = out_l_q;
      out_r_d      = out_r_q;
      capture_d    = 1'b0;
      clk_pdm_d    = 1'b0;
      en_left_d    = 1'b0;
      en_right_d   = 1'b0;
      en_pcm_d     = 1'b0;

      if (!enable || state_q == ST_IDLE) begin
         p_d          = '0;
         d_d          = '0;
         settle_cnt_d = '0;
         out_valid_d  = 1'b0;
         overrun_d    = 1'b0;
         out_l_d      = '0;
         out_r_d      = '0;
         settled_d    = enable && (SETTLE == 0);
      end else begin
         p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
         if (p_q == P_LAST) d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;
         capture_d = en_pcm_q;

         if (capture_q && state_q == ST_SETTLE) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
            if (settle_cnt_q == S_LAST) settled_d = 1'b1;
         end else if (capture_q && state_q == ST_RUN) begin
            out_l_d     = pcm_l_in;
            out_r_d     = pcm_r_in;
            out_valid_d = 1'b1;
            overrun_d   = overrun_q | (out_valid_q & ~out_ready);
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end

      if (state_d != ST_IDLE) begin
         clk_pdm_d  = (p_d >= P_HALF);
         en_left_d  = (p_d == P_LEFT);
         en_right_d = (p_d == P_RIGHT);
         en_pcm_d   = (p_d == P_LAST) && (d_d == D_LAST);
      end
   end

   assign clk_pdm   = clk_pdm_q;
   assign en_left   = en_left_q;
   assign en_right  = en_right_q;
   assign en_pcm    = en_pcm_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;
   assign settled   = settled_q;
   assign out_l     = out_l_q;
   assign out_r     = out_r_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl with default parameters: timing of
// clk_pdm/strobes, settle discard, handshake, overrun and disable behaviour.
module tb_pdm_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst, enable, out_ready;
   logic [15:0] pcm_l_in, pcm_r_in;
   logic        clk_pdm, en_left, en_right, en_pcm;
   logic        out_valid, overrun, settled;
   logic [15:0] out_l, out_r;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int c0, r0, at, prev, strobes;

   pdm_capture_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .clk_pdm   (clk_pdm),
      .en_left   (en_left),
      .en_right  (en_right),
      .en_pcm    (en_pcm),
      .pcm_l_in  (pcm_l_in),
      .pcm_r_in  (pcm_r_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_l     (out_l),
      .out_r     (out_r),
      .overrun   (overrun),
      .settled   (settled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Advance until en_pcm is seen (bounded); returns the cycle stamp.
   task automatic wait_pcm(output int stamp);
      stamp = -1;
      for (int k = 0; k < 3000; k++) begin
         if (en_pcm) begin
            stamp = cyc;
            break;
         end
         step();
      end
      if (stamp < 0) chk("en_pcm_timeout", 32'd0, 32'd1);
   endtask

   // One frame: wait for en_pcm, present data, drive out_ready only in the capture cycle.
   task automatic capture_frame(input logic [15:0] l, input logic [15:0] r,
                                input logic rdy, output int stamp);
      wait_pcm(stamp);
      pcm_l_in = l;
      pcm_r_in = r;
      step();
      out_ready = rdy;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; out_ready = 1'b0;
      pcm_l_in = '0; pcm_r_in = '0;
      repeat (3) step();
      chk("rst_clk_pdm", clk_pdm, 0);
      chk("rst_en_left", en_left, 0);
      chk("rst_en_right", en_right, 0);
      chk("rst_en_pcm", en_pcm, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_settled", settled, 0);
      chk("rst_out_l", out_l, 0);

      // First active cycle has p=0; one full PDM period of clk_pdm and strobes.
      rst = 1'b0;
      step();
      c0 = cyc;
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("clk_pdm_p%0d", k), clk_pdm, k >= 10);
         chk($sformatf("en_left_p%0d", k), en_left, k == 7);
         chk($sformatf("en_right_p%0d", k), en_right, k == 17);
         chk($sformatf("en_pcm_p%0d", k), en_pcm, 0);
         step();
      end

      // Four settle frames are discarded.
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         capture_frame(16'h0100 + 16'(i), 16'h0200 + 16'(i), 1'b0, at);
         if (i == 0) chk("first_en_pcm_cycle", at - c0, 2559);
         else        chk("en_pcm_period", at - prev, 2560);
         prev = at;
         chk("settle_out_valid", out_valid, 0);
         chk("settled_flag", settled, i == 3);
      end

      // Fifth frame is delivered.
      capture_frame(16'h1234, 16'hFFFB, 1'b0, at);
      chk("en_pcm_period5", at - prev, 2560);
      chk("run_out_valid", out_valid, 1);
      chk("run_out_l", out_l, 16'h1234);
      chk("run_out_r", out_r, 16'hFFFB);
      chk("run_overrun", overrun, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("accept_valid_low", out_valid, 0);

      // Two frames without acceptance -> overwrite and sticky overrun.
      capture_frame(16'h0AAA, 16'h0BBB, 1'b0, at);
      chk("ovr_first_valid", out_valid, 1);
      chk("ovr_first_overrun", overrun, 0);
      repeat (100) step();
      chk("hold_out_l", out_l, 16'h0AAA);
      chk("hold_valid", out_valid, 1);
      capture_frame(16'h8001, 16'h7FFF, 1'b0, at);
      chk("ovr_second_valid", out_valid, 1);
      chk("ovr_second_out_l", out_l, 16'h8001);
      chk("ovr_second_out_r", out_r, 16'h7FFF);
      chk("ovr_overrun_set", overrun, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("ovr_accept_valid", out_valid, 0);
      chk("ovr_sticky", overrun, 1);

      // Disable mid-frame.
      repeat (1012) step();
      enable = 1'b0;
      step();
      chk("dis_clk_pdm", clk_pdm, 0);
      chk("dis_out_valid", out_valid, 0);
      chk("dis_settled", settled, 0);
      chk("dis_overrun", overrun, 0);
      strobes = 0;
      repeat (40) begin
         step();
         strobes += int'(en_left) + int'(en_right) + int'(en_pcm) + int'(clk_pdm);
      end
      chk("idle_activity", strobes, 0);

      // Re-enable: phase and decimation restart, settle repeats.
      enable = 1'b1;
      step();
      r0 = cyc;
      chk("reen_clk_pdm_p0", clk_pdm, 0);
      chk("reen_settled", settled, 0);
      repeat (9) step();
      chk("reen_clk_pdm_p9", clk_pdm, 0);
      step();
      chk("reen_clk_pdm_p10", clk_pdm, 1);
      for (int i = 0; i < 4; i++) begin
         capture_frame(16'h0300 + 16'(i), 16'h0400 + 16'(i), 1'b0, at);
         if (i == 0) chk("reen_first_en_pcm", at - r0, 2559);
         chk("reen_settle_valid", out_valid, 0);
         chk("reen_settled_flag", settled, i == 3);
      end

      // Capture and accept in the same cycle.
      capture_frame(16'h5A5A, 16'hA5A5, 1'b0, at);
      chk("same_pre_valid", out_valid, 1);
      chk("same_pre_overrun", overrun, 0);
      capture_frame(16'h0F0F, 16'hF0F0, 1'b1, at);
      chk("same_valid", out_valid, 1);
      chk("same_out_l", out_l, 16'h0F0F);
      chk("same_out_r", out_r, 16'hF0F0);
      chk("same_overrun", overrun, 0);
      step();
      chk("same_valid_hold", out_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
